// File: rtl/handshake_fifo_break_dv.sv
// Elastic circular-buffer FIFO that registers valid and ready on both sides.
// Every output depends only on registered state, so no combinational path
// runs from the upstream side to the downstream side or back.
// When full, ins_ready stays low even if a pop happens in the same cycle.
// A token pushed into an empty FIFO first appears on the cycle after.
module handshake_fifo_break_dv #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];

    logic empty, full, push, pop;

    // Explicit wrap keeps depths that are not a power of two correct
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign ins_ready  = !full;
    assign outs_valid = !empty;
    assign outs       = empty ? '0 : mem_q[head_q];
    assign push       = ins_valid && ins_ready;
    assign pop        = outs_valid && outs_ready;

    // Next-state for the pointers and the occupancy count
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = ptr_next(tail_q);
        end
        if (pop) begin
            head_d = ptr_next(head_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; an asynchronous reset discards all stored tokens
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset: a slot is read only after it has been written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= ins;
        end
    end

endmodule

// File: doc/handshake_fifo_break_dv.md
Name: handshake_fifo_break_dv

Overview:
- Elastic circular-buffer FIFO with registered valid and ready.
- Sits directly downstream of handshake constant / operator stages. It consumes their outs/outs_valid channel and decouples it from the consumer.
- Breaks the combinational data, valid and ready paths between the two sides.
- Absorbs up to NUM_SLOTS tokens so an upstream constant keeps firing while the consumer stalls.

Parameters:
- DATA_WIDTH, 32, token payload width.
- NUM_SLOTS, 4, storage depth. Legal range 2..64, power of two not required.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low: state clears immediately while rst=0.
- ins  input  DATA_WIDTH  upstream token data.
- ins_valid  input  1  upstream token present.
- ins_ready  output  1  FIFO can accept a token this cycle.
- outs  output  DATA_WIDTH  head token data.
- outs_valid  output  1  head token present.
- outs_ready  input  1  downstream accepts head token.

Behaviour:
- State:
  - head pointer and tail pointer, each ceil(log2(NUM_SLOTS)) bits.
  - occupancy counter, ceil(log2(NUM_SLOTS+1)) bits.
  - NUM_SLOTS x DATA_WIDTH storage array.
- Derived flags: empty = (count==0); full = (count==NUM_SLOTS).
- Outputs are pure functions of registered state only:
  - ins_ready = !full.
  - outs_valid = !empty.
  - outs = storage[head] when !empty, else all-zero.
- Handshake events:
  - push = ins_valid & ins_ready.
  - pop = outs_valid & outs_ready.
- push: storage[tail] <= ins; tail advances.
- pop: head advances.
- Pointer advance: ptr <= (ptr==NUM_SLOTS-1) ? 0 : ptr+1. Explicit wrap, correct for non-power-of-two depths.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, or on neither.
- Latency:
  - Minimum one cycle: a token pushed in cycle N is visible on outs/outs_valid in cycle N+1.
  - No same-cycle bypass when empty.
- Full boundary:
  - ins_ready=0 even if a pop happens in the same cycle. No combinational ready pass-through.
  - Throughput at full therefore drops until the next cycle.
- Empty boundary:
  - outs_valid=0 and outs=0.
  - A push while empty does not produce an output that cycle.
- Simultaneous push and pop with 0 < count < NUM_SLOTS:
  - Both pointers advance; count holds.
  - Sustained streaming runs at one token per cycle.
- Ordering: strict FIFO. Tokens are never dropped or duplicated.
- Stability: outs and outs_valid change only after a clock edge, so a stalled head token stays stable while outs_ready=0.
- ins_valid=1 while ins_ready=0: no state change, and the token is not captured.
- Reset, including assertion mid-operation:
  - Asynchronously: head=tail=0, count=0, outs_valid=0, outs=0, ins_ready=1. Stored tokens are discarded.
  - Storage array contents are not reset but are never observable.
  - On deassertion, operation resumes on the first rising edge with rst=1.
- No X propagation: outputs are defined whenever rst=0 or after the first edge following reset.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 3 cycles with ins_valid=1, ins=32'h0A.
  - Required: ins_ready=1, outs_valid=0, outs=0 throughout, with no capture.
- Single token:
  - Stimulus: after reset, push 32'h0A in cycle 1 with outs_ready=1.
  - Required: outs_valid=1, outs=32'h0A in cycle 2; outs_valid=0 in cycle 3.
- Fill and stall:
  - Stimulus: outs_ready=0, push 0x0A,0x0B,0x0C,0x0D on consecutive cycles.
  - Required: ins_ready=0 from the cycle after the 4th push; a 5th token 0x0E is not captured.
  - Required: with outs_ready=1, outputs drain in order 0x0A..0x0D, then ins_ready=1.
- Full with simultaneous pop:
  - Stimulus: at full, assert outs_ready=1 and ins_valid=1.
  - Required: the pop occurs, no push that cycle, count=3; the next cycle accepts the pending token.
- Streaming and wrap:
  - Stimulus: NUM_SLOTS=3, ins_valid=outs_ready=1 for 20 cycles, ins counting 1..20.
  - Required: outs equals 1..20 in order at one per cycle, delayed one cycle, with pointers wrapping 2->0 correctly.
- Mid-operation reset:
  - Stimulus: with 2 tokens stored, pulse rst=0 asynchronously between clock edges.
  - Required: outs_valid drops to 0 immediately; after release the FIFO is empty and accepts new tokens.
